// File: rtl/shift_receiver_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
// SHIFT_RECEIVER_PARITY_EN appends one even-parity bit to every frame.
package shift_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT = 8;

`ifdef SHIFT_RECEIVER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int FRAME_LEN_DEFAULT = DATA_W_DEFAULT + PARITY_BITS;

    // XOR-fold of a zero-extended vector; zero padding does not disturb parity.
    function automatic logic xor_fold(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/rx_shift_reg.sv
// Right-shift register: the serial bit enters at the MSB, so after DATA_W
// shifts the first bit received sits in bit 0.
module rx_shift_reg
    import shift_receiver_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] q
);

    // Shift storage with synchronous clear taking priority over shifting.
    always_ff @(posedge clk) begin
        if (clear) begin
            q <= {DATA_W{1'b0}};
        end else if (shift_en) begin
            q <= {bit_in, q[DATA_W-1:1]};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/shift_receiver.sv
// Serial-to-parallel receiver, LSB first, with valid/ready word output.
// Optional even-parity bit per frame when SHIFT_RECEIVER_PARITY_EN is defined.
module shift_receiver
    import shift_receiver_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              start,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              overrun
);

    localparam int FRAME_LEN = DATA_W + PARITY_BITS;
    localparam int CNT_W     = $clog2(DATA_W + 2);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);

    state_t            state_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] sr_s;
    logic [DATA_W-1:0] word_s;
    logic              perr_s;
    logic              shift_en_s;

    rx_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk      (clk),
        .clear    (reset),
        .shift_en (shift_en_s),
        .bit_in   (bit_in),
        .q        (sr_s)
    );

    // Shift on every accepted data bit; the parity bit is never stored.
    always_comb begin
        shift_en_s = 1'b0;
        if (bit_valid) begin
            case (state_r)
                IDLE:    shift_en_s = start;
                HOLD:    shift_en_s = start;
                RECV:    shift_en_s = start | (count_r < CNT_DATA);
                default: shift_en_s = 1'b0;
            endcase
        end else begin
            shift_en_s = 1'b0;
        end
    end

`ifdef SHIFT_RECEIVER_PARITY_EN
    // Last bit is parity: the data word is already complete in the register.
    always_comb begin
        word_s = sr_s;
        perr_s = xor_fold(64'({sr_s, bit_in}));
    end
`else
    logic unused_sr_lsb_s;
    assign unused_sr_lsb_s = sr_s[0];

    // Last bit is data: present the word as it will look after this shift.
    always_comb begin
        word_s = {bit_in, sr_s[DATA_W-1:1]};
        perr_s = 1'b0;
    end
`endif

    // Frame FSM, bit counter and registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            count_r    <= {CNT_W{1'b0}};
            data_out   <= {DATA_W{1'b0}};
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bit_valid && start) begin
                        state_r <= RECV;
                        count_r <= CNT_ONE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RECV: begin
                    if (bit_valid && start) begin
                        count_r <= CNT_ONE;
                    end else if (bit_valid) begin
                        count_r <= count_r + CNT_ONE;
                        if (count_r == CNT_LAST) begin
                            data_out   <= word_s;
                            parity_err <= perr_s;
                            out_valid  <= 1'b1;
                            state_r    <= HOLD;
                        end else begin
                            state_r <= RECV;
                        end
                    end else begin
                        state_r <= RECV;
                    end
                end
                HOLD: begin
                    // A new frame start always releases the held word; without
                    // a same-cycle handshake that word is lost.
                    if (bit_valid && start) begin
                        state_r   <= RECV;
                        count_r   <= CNT_ONE;
                        out_valid <= 1'b0;
                        overrun   <= ~out_ready;
                    end else if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    count_r   <= {CNT_W{1'b0}};
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_receiver.sv
// Scoreboard bench for shift_receiver; also covers the parity build when
// SHIFT_RECEIVER_PARITY_EN is defined.
module tb_shift_receiver;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic       start;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       parity_err;
    logic       overrun;

    int   tests;
    int   fails;
    int   ov_seen;
    logic prev_pres;
    exp_t exp_q[$];
    exp_t mon_e;

    shift_receiver #(.DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .start      (start),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares each newly presented word against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_pres = 1'b0;
        end else begin
            if (overrun) ov_seen++;
            if (out_valid && !prev_pres) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected none", data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", 32'(data_out), 32'(mon_e.data));
                    check("word_perr", 32'(parity_err), 32'(mon_e.perr));
                end
            end
            prev_pres = out_valid && !out_ready;
        end
    end

    task automatic drive(input logic b, input logic v, input logic s);
        bit_in = b;
        bit_valid = v;
        start = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [7:0] w, input int lo, input int hi, input logic with_start);
        for (int i = lo; i <= hi; i++) drive(w[i], 1'b1, with_start && (i == lo));
    endtask

    task automatic send_par(input logic [7:0] w);
`ifdef SHIFT_RECEIVER_PARITY_EN
        drive(^w, 1'b1, 1'b0);
`else
        if (w === 8'hxx) idle(0);
`endif
    endtask

    task automatic send_frame(input logic [7:0] w);
        send_bits(w, 0, 7, 1'b1);
        send_par(w);
    endtask

    task automatic push(input logic [7:0] w, input logic p);
        exp_q.push_back({w, p});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ov_seen = 0;
        prev_pres = 1'b0;
        reset = 1'b1;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        idle(3);
        reset = 1'b0;
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // Basic frame, bits 1,0,1,1,0,0,1,0 -> 8'h4D
        out_ready = 1'b1;
        push(8'h4D, 1'b0);
        send_frame(8'h4D);
        check("latency_valid", 32'(out_valid), 32'h1);
        idle(1);
        check("hs_valid_drop", 32'(out_valid), 32'h0);
        check("data_retained", 32'(data_out), 32'h4D);

        // Gapped frame 8'h0F
        push(8'h0F, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(((8'h0F >> i) & 8'h01) != 8'h00, 1'b1, i == 0);
            if (i == 3) begin
                idle(3);
                check("gap_no_valid", 32'(out_valid), 32'h0);
            end
            if (i == 6) check("early_no_valid", 32'(out_valid), 32'h0);
        end
        send_par(8'h0F);
        idle(2);

        // Held word dropped by a new start
        out_ready = 1'b0;
        push(8'hA5, 1'b0);
        send_frame(8'hA5);
        idle(2);
        check("held_valid", 32'(out_valid), 32'h1);
        check("held_data", 32'(data_out), 32'hA5);
        push(8'h3C, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        check("overrun_pulse", 32'(overrun), 32'h1);
        check("overrun_valid", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b0);
        check("overrun_one_cycle", 32'(overrun), 32'h0);
        out_ready = 1'b1;
        send_bits(8'h3C, 2, 7, 1'b0);
        send_par(8'h3C);
        idle(2);

        // Abort after 5 bits, restart with 8'hFF
        send_bits(8'h00, 0, 4, 1'b1);
        push(8'hFF, 1'b0);
        send_frame(8'hFF);
        idle(2);

        // Same, but reset lands mid-frame
        send_bits(8'h00, 0, 4, 1'b1);
        send_bits(8'hFF, 0, 3, 1'b1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_data", 32'(data_out), 32'h0);
        send_bits(8'hFF, 4, 7, 1'b0);
        send_par(8'hFF);
        idle(2);
        check("post_rst_valid", 32'(out_valid), 32'h0);
        check("post_rst_data", 32'(data_out), 32'h0);

`ifdef SHIFT_RECEIVER_PARITY_EN
        push(8'h4D, 1'b0);
        send_bits(8'h4D, 0, 7, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        idle(2);
        push(8'h4D, 1'b1);
        send_bits(8'h4D, 0, 7, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        check("perr_flag", 32'(parity_err), 32'h1);
        check("perr_data", 32'(data_out), 32'h4D);
        idle(2);
`endif

        // Back-to-back frames, no idle cycles
        push(8'h01, 1'b0);
        push(8'h80, 1'b0);
        send_frame(8'h01);
        send_frame(8'h80);
        idle(3);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("overrun_count", 32'(ov_seen), 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
